general_register_file: RTL and testbench
========================================

# general_register_file

Operand register file sitting directly upstream of the ALU: eight 16-bit registers (general R1–R4, scratch S1–S4) that receive load data, perform per-register in-place operations, and present two independently selected registers on OutA/OutB, which drive the ALU A and B operand inputs. The ALU result returns to the I input through the system data mux, closing the datapath loop.

## Interface
- WIDTH, 16, register and data width; the ALU operands are 16 bits, so it stays 16 in the system.
- Clock  input  1  rising-edge clock for all state.
- Reset  input  1  synchronous, active-high; clears all eight registers.
- I  input  WIDTH  load data (ALU result or memory data via the system mux).
- RegSel  input  4  one-hot-or-multi enable for R1..R4 (bit0 = R1), active-high.
- ScrSel  input  4  enable for S1..S4 (bit0 = S1), active-high.
- FunSel  input  3  operation applied to every enabled register.
- OutASel  input  3  source for OutA: 000–011 = R1–R4, 100–111 = S1–S4.
- OutBSel  input  3  source for OutB, same encoding.
- OutA  output  WIDTH  selected register, drives ALU A.
- OutB  output  WIDTH  selected register, drives ALU B.

## Operation
- One clock. Reset is synchronous and active-high.
- State: R1..R4 and S1..S4, each WIDTH bits. On reset, all registers become 0x0000, so OutA = OutB = 0x0000.
- On each rising Clock edge with Reset low, every register whose enable bit is 1 applies FunSel. Registers with enable 0 hold their value.
- FunSel encodings:
  - 000 decrement: Q ← Q − 1, mod 2^WIDTH (0x0000 → 0xFFFF).
  - 001 increment: Q ← Q + 1, mod 2^WIDTH (0xFFFF → 0x0000).
  - 010 load: Q ← I.
  - 011 clear: Q ← 0.
  - 100 clear-high, load-low: Q ← {8'h00, I[7:0]}.
  - 101 load low byte: Q[7:0] ← I[7:0]; Q[15:8] holds.
  - 110 load high byte: Q[15:8] ← I[7:0]; Q[7:0] holds.
  - 111 sign-extend load: Q ← {8{I[7]}, I[7:0]}.
- Several enable bits may be active together. Each enabled register applies the operation to its own prior value; for example, increment with RegSel = 4'b1111 increments R1..R4 independently.
- If RegSel and ScrSel are both 0, the cycle is a no-op for state.
- Reads are combinational muxes from the register outputs. OutA and OutB may select the same register.
- No flags are generated here. Carry and borrow on increment/decrement are discarded; the ALU owns the flags.

## Timing
- Write latency: 1 cycle. A value loaded at edge k is visible on OutA/OutB immediately after edge k.
- Read latency: 0 cycles, combinational from current register state and OutASel/OutBSel.
- No read-during-write bypass. In the cycle a register is written, OutA/OutB show its old value until the edge.
- Reset has priority over any FunSel and enable in the same cycle. If Reset is asserted mid-sequence (for example, between an increment burst), all registers are 0 after that edge and the next non-reset edge operates on 0.
- Simultaneous write and read of the same register: the read returns the pre-edge value; after the edge it returns the new value.
- No handshake; the block accepts a command every cycle.

## Test plan
- Reset → after one edge with Reset = 1, OutA = OutB = 0x0000 for all eight OutASel/OutBSel values.
- Load I = 0x1234, RegSel = 0001, FunSel = 010; then load I = 0xABCD, ScrSel = 0100, FunSel = 010 → OutASel = 000 gives 0x1234; OutBSel = 110 gives 0xABCD; all other registers remain 0.
- Wrap-around: R2 = 0xFFFF, increment → 0x0000; then decrement twice → 0xFFFE.
- Byte ops on R3 = 0x1234 with I = 0x0085:
  - FunSel 101 → 0x1285.
  - FunSel 110 → 0x8585.
  - FunSel 111 → 0xFF85.
  - FunSel 100 → 0x0085.
- Multi-select: R1..R4 = 1, 2, 3, 4; RegSel = 1111, FunSel = 001 → 2, 3, 4, 5. ScrSel = 0 and S1..S4 are unchanged.
- Reset priority: Reset = 1 together with RegSel = 1111, FunSel = 010, I = 0x5555 → all registers 0x0000. The next cycle, same command with Reset = 0 → R1..R4 = 0x5555.

Source files
------------

// File: rtl/general_register_file_if.sv
// Operand bus of the general register file: command/select inputs plus the two ALU operand outputs.
interface general_register_file_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] I;
    logic [3:0]       RegSel;
    logic [3:0]       ScrSel;
    logic [2:0]       FunSel;
    logic [2:0]       OutASel;
    logic [2:0]       OutBSel;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;

    modport master (
        output I, RegSel, ScrSel, FunSel, OutASel, OutBSel,
        input  OutA, OutB
    );

    modport slave (
        input  I, RegSel, ScrSel, FunSel, OutASel, OutBSel,
        output OutA, OutB
    );
endinterface

// File: rtl/general_register_file.sv
// Eight-entry operand register file (R1-R4, S1-S4) feeding the ALU A/B operands.
// Every enabled register applies FunSel to its own prior value; reads are combinational.
module general_register_file #(
    parameter int WIDTH = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    general_register_file_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] regs [8];
    logic [7:0]       en;

    // Entries 0-3 are R1-R4, entries 4-7 are S1-S4, matching the OutASel/OutBSel encoding.
    assign en = {bus.ScrSel, bus.RegSel};

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       fs,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] r;
        r = q;
        case (fs)
            3'b000: r = q - ONE;
            3'b001: r = q + ONE;
            3'b010: r = d;
            3'b011: r = '0;
            3'b100: r = {{(WIDTH-8){1'b0}}, d[7:0]};
            3'b101: r[7:0] = d[7:0];
            3'b110: r[15:8] = d[7:0];
            3'b111: r = {{(WIDTH-8){d[7]}}, d[7:0]};
            default: r = q;
        endcase
        return r;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < 8; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (en[k]) regs[k] <= apply_op(bus.FunSel, regs[k], bus.I);
            end
        end
    end

    // No write bypass: a register written this cycle still reads its old value.
    assign bus.OutA = regs[bus.OutASel];
    assign bus.OutB = regs[bus.OutBSel];

endmodule

// File: tb/tb_general_register_file.sv
// Testbench for general_register_file: directed vector table, hand-written corner sequences,
// and randomized commands against an arithmetic reference model.
module tb_general_register_file;

    logic Clock;
    logic Reset;
    int   compared;
    int   mismatched;

    general_register_file_if #(.WIDTH(16)) bus ();

    general_register_file #(.WIDTH(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    typedef struct {
        logic        rst;
        logic [3:0]  rs;
        logic [3:0]  ss;
        logic [2:0]  fs;
        logic [15:0] i;
        logic [2:0]  sel;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [$];
    int   model [8];

    function automatic int ref_op(int fs, int q, int d);
        int lo;
        lo = d % 256;
        case (fs)
            0: return (q + 65535) % 65536;
            1: return (q + 1) % 65536;
            2: return d;
            3: return 0;
            4: return lo;
            5: return (q / 256) * 256 + lo;
            6: return lo * 256 + (q % 256);
            default: return (lo >= 128) ? 65280 + lo : lo;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic [3:0] rs, input logic [3:0] ss,
                         input logic [2:0] fs, input logic [15:0] i);
        Reset      = rst;
        bus.RegSel = rs;
        bus.ScrSel = ss;
        bus.FunSel = fs;
        bus.I      = i;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        Reset      = 1'b0;
        bus.RegSel = 4'b0000;
        bus.ScrSel = 4'b0000;
    endtask

    task automatic chk2(input string name, input logic [2:0] sa, input logic [15:0] ea,
                        input logic [2:0] sb, input logic [15:0] eb);
        bus.OutASel = sa;
        bus.OutBSel = sb;
        #1;
        compared++;
        if (bus.OutA !== ea) begin
            mismatched++;
            $display("FAIL %s OutA(sel=%0d) got %h want %h", name, sa, bus.OutA, ea);
        end
        compared++;
        if (bus.OutB !== eb) begin
            mismatched++;
            $display("FAIL %s OutB(sel=%0d) got %h want %h", name, sb, bus.OutB, eb);
        end
    endtask

    task automatic chk(input string name, input logic [2:0] sel, input logic [15:0] exp);
        chk2(name, sel, exp, sel, exp);
    endtask

    task automatic add(input logic rst, input logic [3:0] rs, input logic [3:0] ss,
                       input logic [2:0] fs, input logic [15:0] i,
                       input logic [2:0] sel, input logic [15:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.rs = rs; v.ss = ss; v.fs = fs; v.i = i;
        v.sel = sel; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic model_step(input logic rst, input logic [3:0] rs, input logic [3:0] ss,
                              input logic [2:0] fs, input logic [15:0] i);
        logic [7:0] en;
        en = {ss, rs};
        for (int k = 0; k < 8; k++) begin
            if (rst) model[k] = 0;
            else if (en[k]) model[k] = ref_op(int'(fs), model[k], int'(i));
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        bus.OutASel = 3'd0;
        bus.OutBSel = 3'd0;
        drive(1'b1, 4'b1111, 4'b1111, 3'b010, 16'hDEAD);
        tick();
        for (int s = 0; s < 8; s++) chk2("reset_sweep", 3'(s), 16'h0000, 3'(7 - s), 16'h0000);

        // Directed vectors: each row applies one command, then reads one register.
        add(0, 4'b0001, 4'b0000, 3'b010, 16'h1234, 3'd0, 16'h1234, "load_R1");
        add(0, 4'b0000, 4'b0100, 3'b010, 16'hABCD, 3'd6, 16'hABCD, "load_S3");
        add(0, 4'b0000, 4'b0000, 3'b001, 16'h0000, 3'd0, 16'h1234, "noop_R1");
        add(0, 4'b0000, 4'b0000, 3'b011, 16'h0000, 3'd1, 16'h0000, "noop_R2");
        add(0, 4'b0000, 4'b0000, 3'b011, 16'h0000, 3'd5, 16'h0000, "noop_S2");
        add(0, 4'b0010, 4'b0000, 3'b010, 16'hFFFF, 3'd1, 16'hFFFF, "load_R2");
        add(0, 4'b0010, 4'b0000, 3'b001, 16'h0000, 3'd1, 16'h0000, "inc_wrap");
        add(0, 4'b0010, 4'b0000, 3'b000, 16'h0000, 3'd1, 16'hFFFF, "dec_wrap");
        add(0, 4'b0010, 4'b0000, 3'b000, 16'h0000, 3'd1, 16'hFFFE, "dec_again");
        add(0, 4'b0100, 4'b0000, 3'b010, 16'h1234, 3'd2, 16'h1234, "load_R3");
        add(0, 4'b0100, 4'b0000, 3'b101, 16'h0085, 3'd2, 16'h1285, "ld_low");
        add(0, 4'b0100, 4'b0000, 3'b110, 16'h0085, 3'd2, 16'h8585, "ld_high");
        add(0, 4'b0100, 4'b0000, 3'b111, 16'h0085, 3'd2, 16'hFF85, "sext");
        add(0, 4'b0100, 4'b0000, 3'b100, 16'h0085, 3'd2, 16'h0085, "clr_hi");
        add(0, 4'b0100, 4'b0000, 3'b011, 16'h0000, 3'd2, 16'h0000, "clear_R3");
        add(0, 4'b0001, 4'b0000, 3'b010, 16'h0001, 3'd0, 16'h0001, "multi_R1");
        add(0, 4'b0010, 4'b0000, 3'b010, 16'h0002, 3'd1, 16'h0002, "multi_R2");
        add(0, 4'b0100, 4'b0000, 3'b010, 16'h0003, 3'd2, 16'h0003, "multi_R3");
        add(0, 4'b1000, 4'b0000, 3'b010, 16'h0004, 3'd3, 16'h0004, "multi_R4");
        add(0, 4'b1111, 4'b0000, 3'b001, 16'h0000, 3'd0, 16'h0002, "multi_inc_R1");
        add(0, 4'b0000, 4'b0000, 3'b001, 16'h0000, 3'd1, 16'h0003, "multi_inc_R2");
        add(0, 4'b0000, 4'b0000, 3'b001, 16'h0000, 3'd2, 16'h0004, "multi_inc_R3");
        add(0, 4'b0000, 4'b0000, 3'b001, 16'h0000, 3'd3, 16'h0005, "multi_inc_R4");
        add(0, 4'b0000, 4'b0000, 3'b001, 16'h0000, 3'd6, 16'hABCD, "multi_S3_hold");
        add(1, 4'b1111, 4'b1111, 3'b010, 16'h5555, 3'd0, 16'h0000, "rst_prio_R1");
        add(0, 4'b0000, 4'b0000, 3'b010, 16'h0000, 3'd6, 16'h0000, "rst_prio_S3");
        add(0, 4'b1111, 4'b0000, 3'b010, 16'h5555, 3'd3, 16'h5555, "post_rst_R4");
        add(0, 4'b0000, 4'b0000, 3'b010, 16'h0000, 3'd0, 16'h5555, "post_rst_R1");

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].rst, vecs[n].rs, vecs[n].ss, vecs[n].fs, vecs[n].i);
            tick();
            chk(vecs[n].name, vecs[n].sel, vecs[n].exp);
        end

        // Read during write: old value until the edge, new value after it.
        drive(1'b0, 4'b0001, 4'b0000, 3'b010, 16'h7777);
        chk("rdw_before", 3'd0, 16'h5555);
        tick();
        chk("rdw_after", 3'd0, 16'h7777);

        // Reset in the middle of an increment burst; the next edge works on zero.
        drive(1'b0, 4'b0000, 4'b0001, 3'b001, 16'h0000);
        tick();
        drive(1'b0, 4'b0000, 4'b0001, 3'b001, 16'h0000);
        tick();
        chk("burst_S1", 3'd4, 16'h0002);
        drive(1'b1, 4'b0000, 4'b0001, 3'b001, 16'h0000);
        tick();
        drive(1'b0, 4'b0000, 4'b0001, 3'b001, 16'h0000);
        tick();
        chk("burst_after_rst", 3'd4, 16'h0001);

        // Randomized commands against the reference model.
        drive(1'b1, 4'b0000, 4'b0000, 3'b000, 16'h0000);
        tick();
        for (int k = 0; k < 8; k++) model[k] = 0;
        for (int n = 0; n < 500; n++) begin
            logic        r_rst;
            logic [3:0]  r_rs;
            logic [3:0]  r_ss;
            logic [2:0]  r_fs;
            logic [15:0] r_i;
            logic [2:0]  sa;
            logic [2:0]  sb;
            r_rst = ($urandom_range(0, 39) == 0);
            r_rs  = 4'($urandom_range(0, 15));
            r_ss  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                r_rs = 4'b0000;
                r_ss = 4'b0000;
            end
            r_fs = 3'($urandom_range(0, 7));
            r_i  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r_i = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
            drive(r_rst, r_rs, r_ss, r_fs, r_i);
            tick();
            model_step(r_rst, r_rs, r_ss, r_fs, r_i);
            sa = 3'($urandom_range(0, 7));
            sb = 3'($urandom_range(0, 7));
            chk2("rand", sa, 16'(model[sa]), sb, 16'(model[sb]));
            if (n % 50 == 49) begin
                for (int s = 0; s < 8; s++) chk("rand_sweep", 3'(s), 16'(model[s]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
